and_two_pipe: RTL and testbench
===============================

Name: and_two_pipe

Overview:
- Parameterised bitwise two-operand AND unit with a registered, valid/ready-handshaked output stage.
- Used as a leaf logic-operation unit in the CPU datapath (ALU logic slice); the output is held stable under backpressure.
- Also produces a registered zero flag alongside the result.

Parameters:
- width, 32, operand and result bit width; legal range is 1 or more.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- input1  input  width  first operand.
- input2  input  width  second operand.
- in_valid  input  1  operands are valid this cycle.
- in_ready  output  1  unit can accept operands this cycle.
- result  output  width  registered input1 & input2.
- zero  output  1  registered flag, 1 when the captured result is all zeros.
- out_valid  output  1  result/zero hold a valid, unconsumed value.
- out_ready  input  1  downstream consumes the result this cycle.

Behaviour:
- Reset (rst=1 at a rising edge): result=0, zero=0, out_valid=0. rst overrides all other inputs in that cycle.
- in_ready = !out_valid || out_ready. This is combinational, with no dependency on in_valid.
- Accept condition: in_valid && in_ready at a rising edge.
- On accept: result <= input1 & input2 (bitwise, all width bits); zero <= ((input1 & input2) == 0); out_valid <= 1.
- Latency: exactly 1 cycle from accept to out_valid=1 with that result.
- Throughput: 1 operation per cycle when out_ready is held at 1.
- Consume without a new accept (out_valid && out_ready && !accept): out_valid <= 0. result and zero keep their last values.
- Simultaneous consume and accept: the new value replaces the old one; out_valid stays 1 with no bubble.
- Stall (out_valid=1, out_ready=0): in_ready=0. result, zero and out_valid hold unchanged. Operands presented during the stall are ignored.
- in_valid=0 with out_valid=0: no state change.
- Reset mid-operation: a pending result is discarded, out_valid returns to 0, and in_ready is 1 on the following cycle.
- No arithmetic carry or width growth; bit i of result depends only on bit i of each operand.

Decomposition:
- Shared package and_two_pkg: AND_TWO_DEFAULT_WIDTH = 32 constant, and a result-plus-flag struct typedef (data, zero) parameterised by width via the module.
- One natural sub-module, and_two_comb: the purely combinational bitwise AND plus zero detect.
- and_two_pipe instantiates and_two_comb and adds the handshake register stage.

Test Plan:
- Reset, then idle: out_valid=0, result=0, zero=0, in_ready=1.
- width=32, out_ready=1: send (00000000, FFFFFFFF) -> next cycle result=00000000, zero=1, out_valid=1.
- Back-to-back stream on consecutive cycles with out_ready=1: (F0F0F0F0, 0F0F0F0F) -> 00000000, zero=1; (0F0F0F0F, 0F0F0F0F) -> 0F0F0F0F, zero=0; (11111111, 33333333) -> 11111111, zero=0. Results appear one per cycle, in order, with no bubbles.
- Backpressure: accept (0F0F0F0F, 0F0F0F0F), then hold out_ready=0 for 3 cycles while driving (FFFFFFFF, FFFFFFFF) with in_valid=1 -> in_ready=0, result stays 0F0F0F0F. Raise out_ready -> the held value is consumed, then FFFFFFFF is accepted.
- Reset mid-stall: out_valid=1 with out_ready=0, assert rst for 1 cycle -> out_valid=0, result=0, zero=0, in_ready=1.
- width=8 instance: (A5, 3C) -> result=24, zero=0; (AA, 55) -> result=00, zero=1.

Source files
------------

// File: rtl/and_two_pkg.sv
// ============================================================================
// Module      : and_two_pkg
// Description : Shared constants for the two-operand AND pipeline unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package and_two_pkg;

    localparam int AND_TWO_DEFAULT_WIDTH = 32;

endpackage : and_two_pkg

`default_nettype wire

// File: rtl/and_two_comb.sv
// ============================================================================
// Module      : and_two_comb
// Description : Purely combinational bitwise AND with all-zero detect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module and_two_comb
    import and_two_pkg::*;
#(
    parameter int WIDTH = AND_TWO_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] w_and;

    assign w_and  = a_i & b_i;
    assign data_o = w_and;
    assign zero_o = ~|w_and;

endmodule : and_two_comb

`default_nettype wire

// File: rtl/and_two_pipe.sv
// ============================================================================
// Module      : and_two_pipe
// Description : Bitwise AND unit with a registered valid/ready output stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module and_two_pipe
    import and_two_pkg::*;
#(
    parameter int WIDTH = AND_TWO_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             zero;
    } res_t;

    logic [WIDTH-1:0] w_and_data;
    logic             w_and_zero;
    logic             w_accept;
    res_t             res_d;
    res_t             res_q;
    logic             valid_d;
    logic             valid_q;

    and_two_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .a_i    (input1),
        .b_i    (input2),
        .data_o (w_and_data),
        .zero_o (w_and_zero)
    );

    // The slot frees up in the same cycle it is drained, so a stream never bubbles.
    assign in_ready = !valid_q || out_ready;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        res_d   = res_q;
        valid_d = valid_q;
        if (w_accept) begin
            res_d.data = w_and_data;
            res_d.zero = w_and_zero;
            valid_d    = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    assign result    = res_q.data;
    assign zero      = res_q.zero;
    assign out_valid = valid_q;

endmodule : and_two_pipe

`default_nettype wire

// File: tb/tb_and_two_pipe.sv
// ============================================================================
// Module      : tb_and_two_pipe
// Description : Scoreboard bench for 32-bit and 8-bit and_two_pipe instances.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_and_two_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] a_in1 = '0, a_in2 = '0, a_result;
    logic        a_in_valid = 1'b0, a_in_ready, a_zero, a_out_valid;
    logic        a_out_ready = 1'b1;

    logic [7:0]  b_in1 = '0, b_in2 = '0, b_result;
    logic        b_in_valid = 1'b0, b_in_ready, b_zero, b_out_valid;
    logic        b_out_ready = 1'b1;

    typedef struct {
        logic [31:0] d;
        logic        z;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    and_two_pipe #(.WIDTH(32)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .input1    (a_in1),
        .input2    (a_in2),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .result    (a_result),
        .zero      (a_zero),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready)
    );

    and_two_pipe #(.WIDTH(8)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .input1    (b_in1),
        .input2    (b_in2),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .result    (b_result),
        .zero      (b_zero),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present one operand pair; the expected response is queued once accept is certain.
    task automatic send(input bit sel, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] e, input logic ez, input bit lat);
        int t = 0;
        @(negedge clk);
        if (sel) begin
            b_in1 = x[7:0]; b_in2 = y[7:0]; b_in_valid = 1'b1;
        end else begin
            a_in1 = x; a_in2 = y; a_in_valid = 1'b1;
        end
        #1;
        while (!(sel ? b_in_ready : a_in_ready) && t < 20) begin
            @(negedge clk); #1; t++;
        end
        if (!(sel ? b_in_ready : a_in_ready)) begin
            n_chk = n_chk + 1; n_fail = n_fail + 1;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end else if (sel) begin
            qb.push_back('{e, ez, cyc, lat});
        end else begin
            qa.push_back('{e, ez, cyc, lat});
        end
    endtask

    task automatic idle();
        @(negedge clk);
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        #2;
        if (!rst && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                n_chk = n_chk + 1; n_fail = n_fail + 1;
                $display("FAIL a_unexpected: got result %h expected no output", a_result);
            end else begin
                e = qa.pop_front();
                chk("a_result", a_result, e.d);
                chk("a_zero", {31'd0, a_zero}, {31'd0, e.z});
                if (e.lat) chk("a_latency", cyc, e.cyc + 1);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        #2;
        if (!rst && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                n_chk = n_chk + 1; n_fail = n_fail + 1;
                $display("FAIL b_unexpected: got result %h expected no output", b_result);
            end else begin
                e = qb.pop_front();
                chk("b_result", {24'd0, b_result}, e.d);
                chk("b_zero", {31'd0, b_zero}, {31'd0, e.z});
                if (e.lat) chk("b_latency", cyc, e.cyc + 1);
            end
        end
    end

    initial begin
        int t;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_result", a_result, 32'd0);
        chk("rst_zero", {31'd0, a_zero}, 32'd0);
        chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);

        send(1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
        idle();

        send(1'b0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 1'b1, 1'b1);
        send(1'b0, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0, 1'b1);
        send(1'b0, 32'h1111_1111, 32'h3333_3333, 32'h1111_1111, 1'b0, 1'b1);
        idle();
        @(negedge clk); #1;
        chk("idle_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("idle_result_kept", a_result, 32'h1111_1111);
        chk("idle_zero_kept", {31'd0, a_zero}, 32'd0);

        // Backpressure: held value survives three stalled cycles with new operands waiting.
        send(1'b0, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0, 1'b0);
        @(negedge clk);
        a_out_ready = 1'b0;
        a_in1 = 32'hFFFF_FFFF; a_in2 = 32'hFFFF_FFFF; a_in_valid = 1'b1;
        repeat (3) begin
            #1;
            chk("stall_in_ready", {31'd0, a_in_ready}, 32'd0);
            chk("stall_result", a_result, 32'h0F0F_0F0F);
            chk("stall_out_valid", {31'd0, a_out_valid}, 32'd1);
            @(negedge clk);
        end
        a_out_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, a_in_ready}, 32'd1);
        qa.push_back('{32'hFFFF_FFFF, 1'b0, cyc, 1'b1});
        idle();

        // Reset while stalled discards the pending result.
        send(1'b0, 32'hAAAA_5555, 32'hFFFF_0000, 32'hAAAA_0000, 1'b0, 1'b0);
        @(negedge clk);
        a_out_ready = 1'b0;
        a_in_valid  = 1'b0;
        #1;
        chk("pre_rst_out_valid", {31'd0, a_out_valid}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        qa.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("midrst_result", a_result, 32'd0);
        chk("midrst_zero", {31'd0, a_zero}, 32'd0);
        chk("midrst_in_ready", {31'd0, a_in_ready}, 32'd1);
        a_out_ready = 1'b1;

        send(1'b1, 32'h0000_00A5, 32'h0000_003C, 32'h0000_0024, 1'b0, 1'b1);
        send(1'b1, 32'h0000_00AA, 32'h0000_0055, 32'h0000_0000, 1'b1, 1'b1);
        send(1'b1, 32'h0000_00FF, 32'h0000_0081, 32'h0000_0081, 1'b0, 1'b1);
        idle();

        t = 0;
        while ((qa.size() != 0 || qb.size() != 0) && t < 20) begin
            @(negedge clk); t++;
        end
        #3;
        n_chk = n_chk + 1;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_and_two_pipe

`default_nettype wire
